// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS run/step/halt sequencer.
// Command opcodes, controller state enum and default counter width.
package mips_ctrl_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_RUN_N    = 2'd0,
    OP_STEP     = 2'd1,
    OP_RUN_FREE = 2'd2,
    OP_RSVD     = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN_N    = 3'd1,
    ST_RUN_FREE = 3'd2,
    ST_STEP     = 3'd3,
    ST_BREAK    = 3'd4
  } state_e;

endpackage

// File: rtl/mips_run_ctrl.sv
// Run/step/halt sequencer gating the datapath cycle-enable; cpu_en is combinational, done/bp_hit registered.
// Commands are taken only in IDLE or BREAK (cmd_ready); halt_req overrides commands and breakpoints.
module mips_run_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              halt_req,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic              cpu_en,
  output logic              busy,
  output logic              halted_bp,
  output logic              done,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_count
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic             bp_skip;
  logic             bp_match;
  logic             done_nxt, bp_hit_nxt;
  logic             load_rem, set_skip;

  assign cmd_ready = (state == ST_IDLE) || (state == ST_BREAK);
  assign busy      = (state == ST_RUN_N) || (state == ST_RUN_FREE) || (state == ST_STEP);
  assign halted_bp = (state == ST_BREAK);
  assign bp_match  = bp_en && (pc == bp_addr) && !bp_skip;
  // STEP deliberately ignores the breakpoint so a debugger can single-step off it.
  assign cpu_en    = busy && !halt_req && !(bp_match && (state != ST_STEP));

  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    bp_hit_nxt = 1'b0;
    load_rem   = 1'b0;
    set_skip   = 1'b0;
    case (state)
      ST_IDLE, ST_BREAK: begin
        if (halt_req) begin
          state_nxt = ST_IDLE;
        end else if (cmd_valid) begin
          set_skip = (state == ST_BREAK);
          case (op_e'(cmd_op))
            OP_RUN_N: begin
              if (cmd_count == '0) begin
                done_nxt = 1'b1;
              end else begin
                state_nxt = ST_RUN_N;
                load_rem  = 1'b1;
              end
            end
            OP_STEP:     state_nxt = ST_STEP;
            OP_RUN_FREE: state_nxt = ST_RUN_FREE;
            default:     ;
          endcase
        end
      end
      ST_RUN_N, ST_RUN_FREE: begin
        if (cpu_en) begin
          if ((state == ST_RUN_N) && (remaining == CNT_W'(1))) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end else if (halt_req) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt  = ST_BREAK;
          bp_hit_nxt = 1'b1;
        end
      end
      ST_STEP: begin
        if (cpu_en || halt_req) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      bp_skip     <= 1'b0;
      cycle_count <= '0;
      done        <= 1'b0;
      bp_hit      <= 1'b0;
    end else begin
      state  <= state_nxt;
      done   <= done_nxt;
      bp_hit <= bp_hit_nxt;
      if (load_rem) begin
        remaining <= cmd_count;
      end else if (cpu_en && (state == ST_RUN_N)) begin
        remaining <= remaining - CNT_W'(1);
      end
      if (cpu_en) begin
        cycle_count <= cycle_count + CNT_W'(1);
        bp_skip     <= 1'b0;
      end else if (set_skip) begin
        bp_skip <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: command table, multi-cycle corner sequences, randomized run vs abstract model.
module tb_mips_run_ctrl;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, halt_req, bp_en;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_count, cycle_count;
  logic [31:0] bp_addr, pc;
  logic        cpu_en, busy, halted_bp, done, bp_hit;
  logic        pc_clr;
  logic        c4_ready, c4_en, c4_busy, c4_halted, c4_done, c4_bphit;
  logic [3:0]  c4_cc;

  int n_chk = 0, n_fail = 0;
  int w_en, w_done, w_bh;

  mips_run_ctrl #(.CNT_W(16), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .halt_req(halt_req), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .cpu_en(cpu_en), .busy(busy), .halted_bp(halted_bp),
    .done(done), .bp_hit(bp_hit), .cycle_count(cycle_count));

  mips_run_ctrl #(.CNT_W(4), .ADDR_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(c4_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count[3:0]), .halt_req(halt_req), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .cpu_en(c4_en), .busy(c4_busy), .halted_bp(c4_halted),
    .done(c4_done), .bp_hit(c4_bphit), .cycle_count(c4_cc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in datapath: PC advances by 4 on every enabled cycle.
  always @(posedge clk) begin
    if (pc_clr) pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic win_clr();
    w_en = 0; w_done = 0; w_bh = 0;
  endtask

  task automatic run_win(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      w_en   += int'(cpu_en);
      w_done += int'(done);
      w_bh   += int'(bp_hit);
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic [1:0] op, input int cnt);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = 16'(cnt);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op; int cnt; bit bpe; int off; int win;
    int en; int dn; int bh; bit hb; int cc;
  } vec_t;
  vec_t tbl[10];

  // Abstract reference: a run budget instead of states.
  bit m_active, m_parked, m_step, m_skip, m_dp, m_bp, match, e_en, nd, nb;
  int m_left, m_cc;

  initial begin
    tbl[0] = '{2'd0, 5, 1'b0, 0, 8, 5, 1, 0, 1'b0, 5};
    tbl[1] = '{2'd1, 0, 1'b1, 0, 3, 1, 1, 0, 1'b0, 6};
    tbl[2] = '{2'd1, 0, 1'b1, 0, 3, 1, 1, 0, 1'b0, 7};
    tbl[3] = '{2'd1, 0, 1'b1, 0, 3, 1, 1, 0, 1'b0, 8};
    tbl[4] = '{2'd2, 0, 1'b1, 12, 6, 3, 0, 1, 1'b1, 11};
    tbl[5] = '{2'd0, 1, 1'b1, 0, 4, 1, 1, 0, 1'b0, 12};
    tbl[6] = '{2'd0, 0, 1'b0, 0, 3, 0, 1, 0, 1'b0, 12};
    tbl[7] = '{2'd3, 7, 1'b0, 0, 3, 0, 0, 0, 1'b0, 12};
    tbl[8] = '{2'd0, 3, 1'b1, 4, 4, 1, 0, 1, 1'b1, 13};
    tbl[9] = '{2'd1, 0, 1'b1, 0, 3, 1, 1, 0, 1'b0, 14};

    rst_n = 1'b0; pc_clr = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = '0;
    halt_req = 1'b0; bp_en = 1'b0; bp_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cpu_en", cpu_en, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", cmd_ready, 1'b1);
    chk("reset_halted", halted_bp, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_bphit", bp_hit, 1'b0);
    chk("reset_cc", cycle_count, 16'd0);
    rst_n = 1'b1; pc_clr = 1'b0;

    for (int i = 0; i < 10; i++) begin
      bp_en = tbl[i].bpe;
      bp_addr = pc + 32'(tbl[i].off);
      win_clr();
      issue(tbl[i].op, tbl[i].cnt);
      run_win(tbl[i].win);
      chk($sformatf("tbl%0d_en", i), w_en, tbl[i].en);
      chk($sformatf("tbl%0d_done", i), w_done, tbl[i].dn);
      chk($sformatf("tbl%0d_bphit", i), w_bh, tbl[i].bh);
      chk($sformatf("tbl%0d_halted", i), halted_bp, tbl[i].hb);
      chk($sformatf("tbl%0d_cc", i), cycle_count, tbl[i].cc);
    end
    bp_en = 1'b0;

    // Halt at the 10th enabled cycle of a long run.
    win_clr();
    issue(2'd0, 100);
    run_win(9);
    halt_req = 1'b1; run_win(1); halt_req = 1'b0;
    run_win(3);
    chk("halt_en", w_en, 9);
    chk("halt_done", w_done, 1);
    chk("halt_busy", busy, 1'b0);
    chk("halt_cc", cycle_count, 16'd23);
    win_clr();
    issue(2'd0, 0);
    run_win(3);
    chk("zero_done", w_done, 1);
    chk("zero_cc", cycle_count, 16'd23);

    // Halt coincident with accept drops the command.
    win_clr();
    halt_req = 1'b1; issue(2'd2, 0); halt_req = 1'b0;
    run_win(4);
    chk("haltacc_en", w_en, 0);
    chk("haltacc_done", w_done, 0);
    chk("haltacc_busy", busy, 1'b0);

    // Halt and breakpoint in the same cycle: halt wins.
    bp_en = 1'b1; bp_addr = pc + 32'd8;
    win_clr();
    issue(2'd2, 0);
    run_win(2);
    halt_req = 1'b1; run_win(1); halt_req = 1'b0;
    run_win(3);
    bp_en = 1'b0;
    chk("haltbp_en", w_en, 2);
    chk("haltbp_done", w_done, 1);
    chk("haltbp_bphit", w_bh, 0);
    chk("haltbp_halted", halted_bp, 1'b0);
    chk("haltbp_cc", cycle_count, 16'd25);

    // Asynchronous reset in the middle of a free run.
    issue(2'd2, 0);
    run_win(3);
    chk("arst_pre_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cpu_en", cpu_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cc", cycle_count, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("arst_ready", cmd_ready, 1'b1);

    // Narrow counter wraps 15 -> 0 -> 1.
    issue(2'd0, 15);
    run_win(18);
    chk("wrap_15", c4_cc, 4'd15);
    issue(2'd1, 0); run_win(3);
    chk("wrap_0", c4_cc, 4'd0);
    issue(2'd1, 0); run_win(3);
    chk("wrap_1", c4_cc, 4'd1);
    chk("wrap_wide", cycle_count, 16'd17);

    // Randomized run against the abstract model.
    rst_n = 1'b0; #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_active = 0; m_parked = 0; m_step = 0; m_skip = 0; m_dp = 0; m_bp = 0;
    m_left = 0; m_cc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      match = bp_en && (pc == bp_addr) && !m_skip;
      e_en  = m_active && !halt_req && !(match && !m_step);
      chk("rnd_cpu_en", cpu_en, e_en);
      chk("rnd_busy", busy, m_active);
      chk("rnd_halted", halted_bp, m_parked);
      chk("rnd_ready", cmd_ready, !m_active);
      chk("rnd_done", done, m_dp);
      chk("rnd_bphit", bp_hit, m_bp);
      chk("rnd_cc", cycle_count, m_cc);
      nd = 0; nb = 0;
      if (e_en) begin
        m_cc = (m_cc + 1) % 65536;
        m_skip = 0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin m_active = 0; nd = 1; end
        end
      end else if (m_active) begin
        m_active = 0;
        if (halt_req) nd = 1;
        else begin m_parked = 1; nb = 1; end
      end else if (halt_req) begin
        m_parked = 0;
      end else if (cmd_valid) begin
        if (m_parked) m_skip = 1;
        if (cmd_op == 2'd0 && cmd_count == 0) nd = 1;
        else if (cmd_op != 2'd3) begin
          m_active = 1; m_parked = 0;
          m_step = (cmd_op == 2'd1);
          m_left = (cmd_op == 2'd2) ? -1 : (cmd_op == 2'd1) ? 1 : int'(cmd_count);
        end
      end
      m_dp = nd; m_bp = nb;
      @(posedge clk); #1;
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_count = 16'($urandom_range(0, 6));
      halt_req  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        bp_en   = 1'($urandom_range(0, 1));
        bp_addr = pc + 32'(4 * $urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
